// File: rtl/fc2_mac_if.sv
// Layer-2 weight ROM port bundle: address/enable pins driven by the MAC
// engine, registered read data returned by the ROM.
interface fc2_mac_if;
  logic        ce;
  logic        oce;
  logic        reset;
  logic [7:0]  ad;
  logic [15:0] dout;

  modport master (output ce, output oce, output reset, output ad, input dout);
  modport slave  (input ce, input oce, input reset, input ad, output dout);
endinterface

// File: rtl/fc2_mac.sv
// Second fully-connected layer: streams 150 signed weights from the ROM,
// multiplies each by the latched hidden activation, accumulates one score
// per output neuron and tracks the argmax class.
module fc2_mac #(
  parameter int N_IN  = 15,
  parameter int N_OUT = 10,
  parameter int ACC_W = 40
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [16*N_IN-1:0]      hid_vec,
  fc2_mac_if.master               rom,
  output logic                    busy,
  output logic                    score_valid,
  output logic [3:0]              score_idx,
  output logic signed [ACC_W-1:0] score,
  output logic                    done,
  output logic [3:0]              class_id,
  output logic signed [ACC_W-1:0] max_score
);

  localparam logic [7:0] LAST_AD = 8'(N_IN * N_OUT - 1);
  localparam logic [3:0] LAST_I  = 4'(N_IN - 1);
  localparam logic [3:0] LAST_O  = 4'(N_OUT - 1);
  localparam logic signed [ACC_W-1:0] MOST_NEG = {1'b1, {(ACC_W-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN} state_t;

  state_t r_state, w_state_next;
  logic   w_ce, w_busy, w_accept;

  // Fetch side: address and the (input, neuron) indices that travel with it
  logic [16*N_IN-1:0] r_hid;
  logic [7:0]         r_ad;
  logic [3:0]         r_i, r_o;
  // Same indices delayed one cycle to line up with the ROM's registered dout
  logic               r_p_vld;
  logic [3:0]         r_p_i, r_p_o;

  logic signed [ACC_W-1:0] r_acc, r_score, r_max;
  logic                    r_score_valid, r_done;
  logic [3:0]              r_score_idx, r_class;

  logic signed [15:0]      w_act_arr [N_IN];
  logic signed [15:0]      w_act, w_wgt;
  logic signed [31:0]      w_prod;
  logic signed [ACC_W-1:0] w_prod_ext, w_acc_sum;

  // Unpack the latched activation vector so it can be indexed by input number
  generate
    for (genvar gi = 0; gi < N_IN; gi++) begin : g_act
      assign w_act_arr[gi] = r_hid[16*gi +: 16];
    end
  endgenerate

  assign w_act      = w_act_arr[r_p_i];
  assign w_wgt      = rom.dout;
  assign w_prod     = w_act * w_wgt;
  assign w_prod_ext = {{(ACC_W-32){w_prod[31]}}, w_prod};
  // First input of a neuron reloads the accumulator instead of adding
  assign w_acc_sum  = (r_p_i == 4'd0) ? w_prod_ext : r_acc + w_prod_ext;
  assign w_accept   = (r_state == S_IDLE) && start;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  // Next-state and control decode
  always_comb begin
    w_state_next = r_state;
    w_ce         = 1'b0;
    w_busy       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_state_next = S_FETCH;
      end
      S_FETCH: begin
        w_ce   = 1'b1;
        w_busy = 1'b1;
        if (r_ad == LAST_AD) w_state_next = S_DRAIN;
      end
      S_DRAIN: begin
        w_busy = 1'b1;
        if (r_done) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Latch activations on accept, walk the ROM address space once per run
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_hid   <= '0;
      r_ad    <= '0;
      r_i     <= '0;
      r_o     <= '0;
      r_p_vld <= 1'b0;
      r_p_i   <= '0;
      r_p_o   <= '0;
    end else begin
      r_p_vld <= w_ce;
      r_p_i   <= r_i;
      r_p_o   <= r_o;
      if (w_accept) begin
        r_hid <= hid_vec;
        r_ad  <= '0;
        r_i   <= '0;
        r_o   <= '0;
      end else if (w_ce) begin
        r_ad <= (r_ad == LAST_AD) ? 8'd0 : r_ad + 8'd1;
        if (r_i == LAST_I) begin
          r_i <= '0;
          r_o <= (r_o == LAST_O) ? 4'd0 : r_o + 4'd1;
        end else begin
          r_i <= r_i + 4'd1;
        end
      end
    end
  end

  // Multiply-accumulate and per-neuron score emission
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_acc         <= '0;
      r_score       <= '0;
      r_score_idx   <= '0;
      r_score_valid <= 1'b0;
    end else begin
      r_score_valid <= 1'b0;
      if (w_accept) begin
        r_acc <= '0;
      end else if (r_p_vld) begin
        r_acc <= w_acc_sum;
        if (r_p_i == LAST_I) begin
          r_score_valid <= 1'b1;
          r_score       <= w_acc_sum;
          r_score_idx   <= r_p_o;
        end
      end
    end
  end

  // Argmax tracking (strictly greater, so ties keep the lower index) and done
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_max   <= '0;
      r_class <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= r_score_valid && (r_score_idx == LAST_O);
      if (w_accept) begin
        r_max   <= MOST_NEG;
        r_class <= '0;
      end else if (r_score_valid && (r_score > r_max)) begin
        r_max   <= r_score;
        r_class <= r_score_idx;
      end
    end
  end

  assign rom.ce      = w_ce;
  assign rom.oce     = w_busy;
  assign rom.reset   = ~rst_n;
  assign rom.ad      = r_ad;
  assign busy        = w_busy;
  assign score_valid = r_score_valid;
  assign score_idx   = r_score_idx;
  assign score       = r_score;
  assign done        = r_done;
  assign class_id    = r_class;
  assign max_score   = r_max;

endmodule

// File: tb/tb_fc2_mac.sv
// Self-checking bench for fc2_mac: behavioural ROM, dot-product reference
// model and per-scenario checks of scores, timing, argmax and reset.
module tb_fc2_mac;
  localparam int N_IN      = 15;
  localparam int N_OUT     = 10;
  localparam int ACC_W     = 40;
  localparam int CYC_LIMIT = 220;

  logic                    clk     = 1'b0;
  logic                    rst_n   = 1'b0;
  logic                    start   = 1'b0;
  logic [16*N_IN-1:0]      hid_vec = '0;
  logic                    busy, score_valid, done;
  logic [3:0]              score_idx, class_id;
  logic signed [ACC_W-1:0] score, max_score;

  fc2_mac_if rom_if ();

  fc2_mac #(.N_IN(N_IN), .N_OUT(N_OUT), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .hid_vec(hid_vec), .rom(rom_if),
    .busy(busy), .score_valid(score_valid), .score_idx(score_idx), .score(score),
    .done(done), .class_id(class_id), .max_score(max_score)
  );

  initial forever #5 clk = ~clk;

  // Behavioural ROM: registered read, one cycle latency
  logic signed [15:0] wmem [256];
  always @(posedge clk) if (rom_if.ce) rom_if.dout <= wmem[rom_if.ad];

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic signed [15:0] hid_arr [N_IN];
  longint exp_score [N_OUT];
  int     exp_class;
  longint exp_max;

  // Captured observations of one run (cycle 0 = start-sample cycle)
  int     cap_sv_cyc[$];
  int     cap_sv_idx[$];
  longint cap_sv_score[$];
  int     cap_ce_cyc[$];
  int     cap_ad[$];
  int     cap_done_cyc, cap_class, cap_busy_first, cap_busy_last, cap_busy_cnt;
  int     cap_oce_bad, cap_rst_bad;
  longint cap_max;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [16*N_IN-1:0] pack_hid();
    logic [16*N_IN-1:0] v;
    for (int i = 0; i < N_IN; i++) v[16*i +: 16] = hid_arr[i];
    return v;
  endfunction

  // Dot product per neuron, then first-index-wins argmax
  task automatic model();
    for (int o = 0; o < N_OUT; o++) begin
      longint s = 0;
      for (int i = 0; i < N_IN; i++)
        s += longint'(hid_arr[i]) * longint'(wmem[o*N_IN + i]);
      exp_score[o] = s;
    end
    exp_class = 0;
    exp_max   = exp_score[0];
    for (int o = 1; o < N_OUT; o++)
      if (exp_score[o] > exp_max) begin
        exp_max   = exp_score[o];
        exp_class = o;
      end
  endtask

  task automatic randomize_all();
    for (int a = 0; a < 256; a++) wmem[a] = 16'($urandom);
    for (int i = 0; i < N_IN; i++) hid_arr[i] = 16'($urandom);
  endtask

  task automatic launch();
    tick();
    hid_vec = pack_hid();
    start   = 1'b1;
    model();
  endtask

  // Record DUT activity until done or the cycle budget expires
  task automatic capture(input bit hold_start, input bit scramble);
    cap_sv_cyc.delete(); cap_sv_idx.delete(); cap_sv_score.delete();
    cap_ce_cyc.delete(); cap_ad.delete();
    cap_done_cyc = -1; cap_busy_first = -1; cap_busy_last = -1; cap_busy_cnt = 0;
    cap_oce_bad = 0; cap_rst_bad = 0; cap_class = -1; cap_max = 0;
    for (int c = 0; c < CYC_LIMIT; c++) begin
      @(negedge clk);
      if (rom_if.ce === 1'b1) begin
        cap_ce_cyc.push_back(c);
        cap_ad.push_back(int'(rom_if.ad));
      end
      if (busy === 1'b1) begin
        if (cap_busy_first < 0) cap_busy_first = c;
        cap_busy_last = c;
        cap_busy_cnt++;
      end
      if (rom_if.oce !== busy) cap_oce_bad++;
      if (rom_if.reset !== ~rst_n) cap_rst_bad++;
      if (score_valid === 1'b1) begin
        cap_sv_cyc.push_back(c);
        cap_sv_idx.push_back(int'(score_idx));
        cap_sv_score.push_back(longint'(score));
      end
      if (done === 1'b1) begin
        cap_done_cyc = c;
        cap_class    = int'(class_id);
        cap_max      = longint'(max_score);
        break;
      end
      tick();
      if (!hold_start) start = 1'b0;
      if (scramble && c == 4) hid_vec = {8{$urandom}};
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    n_checks++;
    if ({busy, rom_if.ce, rom_if.oce, score_valid, done} !== 5'b0) begin
      n_errors++;
      $display("FAIL reset_ctrl: got busy/ce/oce/sv/done=%b required 00000",
               {busy, rom_if.ce, rom_if.oce, score_valid, done});
    end
    n_checks++;
    if (rom_if.ad !== 8'd0 || score_idx !== 4'd0 || score !== '0 || class_id !== 4'd0 || max_score !== '0) begin
      n_errors++;
      $display("FAIL reset_data: got ad=%0d idx=%0d score=%0d class=%0d max=%0d required all 0",
               rom_if.ad, score_idx, score, class_id, max_score);
    end
    n_checks++;
    if (rom_if.reset !== 1'b1) begin
      n_errors++;
      $display("FAIL reset_rom_reset_low: got %b required 1", rom_if.reset);
    end
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (rom_if.reset !== 1'b0 || busy !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_release: got rom_reset=%b busy=%b required 0 0", rom_if.reset, busy);
    end
    $display("test_reset: done");
  endtask

  task automatic test_ones();
    int bad_ad = 0;
    for (int a = 0; a < 256; a++) wmem[a] = 16'($urandom);
    for (int i = 0; i < N_IN; i++) hid_arr[i] = 16'sd1;
    launch();
    capture(1'b0, 1'b0);
    n_checks++;
    if (cap_sv_cyc.size() != N_OUT) begin
      n_errors++;
      $display("FAIL ones_sv_count: got %0d required %0d", cap_sv_cyc.size(), N_OUT);
    end
    for (int k = 0; k < N_OUT && k < cap_sv_cyc.size(); k++) begin
      n_checks++;
      if (cap_sv_cyc[k] != 15*(k+1)+2 || cap_sv_idx[k] != k || cap_sv_score[k] != exp_score[k]) begin
        n_errors++;
        $display("FAIL ones_score%0d: got cyc=%0d idx=%0d score=%0d required cyc=%0d idx=%0d score=%0d",
                 k, cap_sv_cyc[k], cap_sv_idx[k], cap_sv_score[k], 15*(k+1)+2, k, exp_score[k]);
      end
      $display("ones: neuron %0d score %0d at cycle %0d", cap_sv_idx[k], cap_sv_score[k], cap_sv_cyc[k]);
    end
    n_checks++;
    if (cap_done_cyc != 153 || cap_class != exp_class || cap_max != exp_max) begin
      n_errors++;
      $display("FAIL ones_done: got cyc=%0d class=%0d max=%0d required cyc=153 class=%0d max=%0d",
               cap_done_cyc, cap_class, cap_max, exp_class, exp_max);
    end
    n_checks++;
    if (cap_ce_cyc.size() != 150) begin
      n_errors++;
      $display("FAIL addr_count: got %0d ce cycles required 150", cap_ce_cyc.size());
    end
    for (int k = 0; k < cap_ce_cyc.size(); k++)
      if (cap_ce_cyc[k] != k+1 || cap_ad[k] != k) bad_ad++;
    n_checks++;
    if (bad_ad != 0) begin
      n_errors++;
      $display("FAIL addr_walk: got %0d misplaced addresses required 0", bad_ad);
    end
    n_checks++;
    if (cap_busy_first != 1 || cap_busy_last != 153 || cap_busy_cnt != 153) begin
      n_errors++;
      $display("FAIL busy_window: got first=%0d last=%0d cnt=%0d required 1 153 153",
               cap_busy_first, cap_busy_last, cap_busy_cnt);
    end
    n_checks++;
    if (cap_oce_bad != 0 || cap_rst_bad != 0) begin
      n_errors++;
      $display("FAIL oce_reset_track: got oce_bad=%0d rst_bad=%0d required 0 0", cap_oce_bad, cap_rst_bad);
    end
    $display("test_ones: class %0d max %0d done at cycle %0d", cap_class, cap_max, cap_done_cyc);
  endtask

  task automatic test_random();
    for (int r = 0; r < 3; r++) begin
      randomize_all();
      launch();
      capture(1'b0, 1'b0);
      for (int k = 0; k < N_OUT && k < cap_sv_score.size(); k++) begin
        n_checks++;
        if (cap_sv_score[k] != exp_score[k]) begin
          n_errors++;
          $display("FAIL rand%0d_score%0d: got %0d required %0d", r, k, cap_sv_score[k], exp_score[k]);
        end
      end
      n_checks++;
      if (cap_sv_score.size() != N_OUT || cap_done_cyc != 153 || cap_class != exp_class || cap_max != exp_max) begin
        n_errors++;
        $display("FAIL rand%0d_result: got n=%0d done=%0d class=%0d max=%0d required 10 153 %0d %0d",
                 r, cap_sv_score.size(), cap_done_cyc, cap_class, cap_max, exp_class, exp_max);
      end
      $display("random run %0d: class %0d max %0d", r, cap_class, cap_max);
    end
  endtask

  task automatic test_extreme();
    for (int a = 0; a < 256; a++) wmem[a] = 16'($urandom);
    wmem[0] = -16'sd32768;
    for (int i = 0; i < N_IN; i++) hid_arr[i] = 16'sd0;
    hid_arr[0] = 16'sh7FFF;
    launch();
    capture(1'b0, 1'b0);
    n_checks++;
    if (cap_sv_score.size() < 1 || cap_sv_score[0] != -64'sd1073709056) begin
      n_errors++;
      $display("FAIL extreme_score0: got %0d required -1073709056",
               (cap_sv_score.size() > 0) ? cap_sv_score[0] : 64'sd0);
    end
    n_checks++;
    if (cap_class != exp_class || cap_max != exp_max) begin
      n_errors++;
      $display("FAIL extreme_argmax: got class=%0d max=%0d required %0d %0d",
               cap_class, cap_max, exp_class, exp_max);
    end
    $display("test_extreme: score0 %0d class %0d", (cap_sv_score.size() > 0) ? cap_sv_score[0] : 64'sd0, cap_class);
  endtask

  task automatic test_tie();
    for (int i = 0; i < N_IN; i++) hid_arr[i] = 16'sd1;
    for (int a = 0; a < 256; a++) wmem[a] = 16'($signed($urandom_range(1000, 0)) - 500);
    for (int i = 0; i < N_IN; i++) begin
      wmem[3*N_IN + i] = 16'($urandom_range(2000, 1000));
      wmem[7*N_IN + i] = wmem[3*N_IN + i];
    end
    launch();
    capture(1'b0, 1'b0);
    n_checks++;
    if (cap_class != 3 || cap_max != exp_score[7]) begin
      n_errors++;
      $display("FAIL tie_argmax: got class=%0d max=%0d required 3 %0d", cap_class, cap_max, exp_score[7]);
    end
    $display("test_tie: class %0d max %0d", cap_class, cap_max);
  endtask

  task automatic test_reset_mid();
    int done_seen = 0;
    randomize_all();
    launch();
    for (int c = 0; c < 65; c++) begin
      if (c == 1)  start = 1'b0;
      if (c == 60) rst_n = 1'b0;
      if (c == 62) rst_n = 1'b1;
      @(negedge clk);
      if (done === 1'b1) done_seen++;
      if (c == 61) begin
        n_checks++;
        if ({busy, rom_if.ce, rom_if.oce, score_valid, done} !== 5'b0 || rom_if.ad !== 8'd0 ||
            score_idx !== 4'd0 || score !== '0 || class_id !== 4'd0 || max_score !== '0 || rom_if.reset !== 1'b1) begin
          n_errors++;
          $display("FAIL midreset_outputs: got busy=%b ce=%b ad=%0d idx=%0d score=%0d class=%0d max=%0d rom_reset=%b required all 0, rom_reset 1",
                   busy, rom_if.ce, rom_if.ad, score_idx, score, class_id, max_score, rom_if.reset);
        end
      end
      tick();
    end
    n_checks++;
    if (done_seen != 0) begin
      n_errors++;
      $display("FAIL midreset_no_done: got %0d done pulses required 0", done_seen);
    end
    start = 1'b1;
    capture(1'b0, 1'b0);
    n_checks++;
    if (cap_done_cyc + 65 != 218 || cap_class != exp_class || cap_max != exp_max) begin
      n_errors++;
      $display("FAIL midreset_rerun: got done=%0d class=%0d max=%0d required 218 %0d %0d",
               cap_done_cyc + 65, cap_class, cap_max, exp_class, exp_max);
    end
    for (int k = 0; k < N_OUT && k < cap_sv_score.size(); k++) begin
      n_checks++;
      if (cap_sv_score[k] != exp_score[k]) begin
        n_errors++;
        $display("FAIL midreset_score%0d: got %0d required %0d", k, cap_sv_score[k], exp_score[k]);
      end
    end
    $display("test_reset_mid: rerun done at cycle %0d class %0d", cap_done_cyc + 65, cap_class);
  endtask

  task automatic test_back_to_back();
    randomize_all();
    launch();
    capture(1'b1, 1'b1);
    n_checks++;
    if (cap_done_cyc != 153 || cap_sv_score.size() != N_OUT || cap_class != exp_class || cap_max != exp_max) begin
      n_errors++;
      $display("FAIL b2b_run1: got done=%0d n=%0d class=%0d max=%0d required 153 10 %0d %0d",
               cap_done_cyc, cap_sv_score.size(), cap_class, cap_max, exp_class, exp_max);
    end
    for (int k = 0; k < N_OUT && k < cap_sv_score.size(); k++) begin
      n_checks++;
      if (cap_sv_score[k] != exp_score[k]) begin
        n_errors++;
        $display("FAIL b2b_run1_score%0d: got %0d required %0d", k, cap_sv_score[k], exp_score[k]);
      end
    end
    $display("b2b run 1: class %0d done at %0d", cap_class, cap_done_cyc);
    // Cycle 154: start is still high and must be accepted here
    tick();
    for (int i = 0; i < N_IN; i++) hid_arr[i] = 16'($urandom);
    hid_vec = pack_hid();
    model();
    capture(1'b0, 1'b0);
    n_checks++;
    if (cap_busy_first != 1 || cap_done_cyc != 153) begin
      n_errors++;
      $display("FAIL b2b_run2_timing: got busy_first=%0d done=%0d (relative to cycle 154) required 1 153",
               cap_busy_first, cap_done_cyc);
    end
    n_checks++;
    if (cap_class != exp_class || cap_max != exp_max || cap_sv_score.size() != N_OUT) begin
      n_errors++;
      $display("FAIL b2b_run2_result: got class=%0d max=%0d n=%0d required %0d %0d 10",
               cap_class, cap_max, cap_sv_score.size(), exp_class, exp_max);
    end
    $display("b2b run 2: class %0d done at %0d", cap_class, cap_done_cyc);
  endtask

  initial begin
    test_reset();
    test_ones();
    test_random();
    test_extreme();
    test_tie();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fc2_mac.md
# fc2_mac

Second fully-connected layer engine for the digit classifier. It latches the hidden-layer activation vector and streams the layer-2 weights out of the 256×16 layer-2 weight ROM, one address per cycle. It performs a signed multiply-accumulate per output neuron, emits each class score as it completes, and reports the argmax class. It sits directly downstream of the layer-2 weight ROM and drives that ROM's ce/oce/reset/ad pins. It consumes the ROM's registered `dout`.

## Interface
Parameters:
- `N_IN`, 15, hidden activations per output neuron.
- `N_OUT`, 10, output classes.
- `ACC_W`, 40, accumulator/score width (signed).

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset; synchronous and active-low.
- `start`  in  1  request inference; sampled only in IDLE.
- `hid_vec`  in  16·N_IN  signed activations; element i is bits [16i+15:16i]; latched on the accepted start.
- `rom_ce`  out  1  ROM clock enable.
- `rom_oce`  out  1  ROM output enable.
- `rom_reset`  out  1  ROM reset, equal to ~rst_n (combinational).
- `rom_ad`  out  8  ROM word address.
- `rom_dout`  in  16  signed weight; valid the cycle after its address is presented with rom_ce=1.
- `busy`  out  1  high from the cycle after start is accepted until done.
- `score_valid`  out  1  one-cycle pulse per completed neuron.
- `score_idx`  out  4  neuron index for score_valid.
- `score`  out  ACC_W  signed neuron sum.
- `done`  out  1  one-cycle pulse; class_id/max_score valid and held until the next start.
- `class_id`  out  4  argmax class.
- `max_score`  out  ACC_W  score of class_id.

## Operation
- Weight layout: the weight for neuron o, input i is at address o·N_IN+i, addresses 0..N_IN·N_OUT−1 (0..149). Addresses ≥150 are never issued.
- States:
  - IDLE: rom_ce=0, busy=0. On start=1, latch hid_vec, clear the accumulator, load argmax with class 0 / most-negative value, go to FETCH.
  - FETCH: rom_ce=1; rom_ad counts 0..149, one per cycle, with a parallel input index i (0..N_IN−1) and neuron index o. After address 149 is issued, go to DRAIN.
  - DRAIN: rom_ce=0; completes the in-flight MAC, the final score and the argmax update, then pulses done and returns to IDLE.
- rom_oce = busy.
- MAC:
  - product = signed 16×16 → 32 bits, sign-extended to ACC_W.
  - The accumulator is loaded (not added) on i=0 and adds on i>0. No saturation; ACC_W guarantees no overflow.
- Neuron completion: the cycle after the i=N_IN−1 product is accumulated, score_valid=1, score=sum, score_idx=o.
- Argmax: on each score_valid, replace the current best only if score > max (strictly greater). On a tie the lower index wins.
- A start pulse while busy is ignored and the latched hid_vec is unaffected. start in the same cycle as done is ignored; it is accepted the following cycle if still high.
- rst_n=0 at any time, including mid-inference:
  - Next state IDLE; the in-flight result is discarded.
  - busy, rom_ce, rom_oce, score_valid, done = 0.
  - rom_ad, score_idx, score, class_id, max_score = 0.
  - No done pulse is produced for the aborted run.

## Timing
- Cycle 0: start sampled in IDLE.
- Cycles 1..150: rom_ad = 0..149 with rom_ce=1.
- Weight for the address issued in cycle t is on rom_dout in cycle t+1 and is accumulated at the end of cycle t+1.
- score_valid for neuron o is in cycle 15(o+1)+2 (neuron 0 at cycle 17, neuron 9 at cycle 152).
- done is in cycle 153 (N_IN·N_OUT+3). busy is high in cycles 1..153.
- The earliest next start is accepted in cycle 154.
- Throughput: one product per cycle, no bubbles.

## Test plan
- All hid_vec elements = 1, real layer-2 ROM contents:
  - The ten scores equal the per-neuron sums of the signed ROM words.
  - score_valid is at cycles 17, 32, …, 152 and done at 153.
  - class_id equals the golden argmax.
- hid_vec = 0 except element 0 = 0x7FFF, ROM model holding −32768 at address 0:
  - score[0] = −1073709056, with no wrap in ACC_W.
- Tie: model ROM makes neurons 3 and 7 equal maxima -> class_id=3.
- Reset mid-run: deassert rst_n at cycle 60, release at 62, then start at 65:
  - No done is produced for the first run.
  - All outputs are 0 during reset.
  - The second run completes with done at 65+153 = 218 and correct results.
- start held high continuously:
  - Runs are back-to-back with starts accepted at cycles 0 and 154.
  - An hid_vec change during busy has no effect on the scores.
- Address sequence check: rom_ad walks 0..149 exactly once per run, rom_ce=0 outside cycles 1..150, and rom_reset tracks ~rst_n.
